// File: rtl/reconf_fir_filter.sv
// reconf_fir_filter
// 40-tap FIR filter with runtime-loadable coefficients held in four
// 10-word banks. An external sequencer walks the RAM address and drives
// the multiply/accumulate strobes. Each bank has its own read register,
// tap register, product register and accumulator. The four accumulators
// are summed and saturated into the registered output.
//
// Ports
//   iClk12M          in   clock, rising edge
//   iRsn             in   synchronous reset, active high
//   iEnSample600k    in   sample strobe, shifts the delay line
//   iCoeffUpdateFlag in   1 = coefficient load mode (writes on, reads off)
//   iCsnRam          in   RAM chip select, active low
//   iWrnRam          in   RAM write enable, active low
//   iEnMul           in   product register enable
//   iEnAddAcc        in   accumulate enable
//   iAddrRam         in   [5:4] bank, [3:0] word
//   iWtDtRam         in   coefficient write data
//   iFirIn           in   input sample, signed
//   oFirOut          out  filter output, signed, saturated
module reconf_fir_filter #(
  parameter int NUM_BANK      = 4,
  parameter int TAPS_PER_BANK = 10,
  parameter int COEFF_W       = 16,
  parameter int IN_W          = 3,
  parameter int ACC_W         = 24,
  parameter int OUT_W         = 16
) (
  input  logic               iClk12M,
  input  logic               iRsn,
  input  logic               iEnSample600k,
  input  logic               iCoeffUpdateFlag,
  input  logic               iCsnRam,
  input  logic               iWrnRam,
  input  logic               iEnMul,
  input  logic               iEnAddAcc,
  input  logic [5:0]         iAddrRam,
  input  logic [COEFF_W-1:0] iWtDtRam,
  input  logic [IN_W-1:0]    iFirIn,
  output logic [OUT_W-1:0]   oFirOut
);

  localparam int NUM_TAP = NUM_BANK * TAPS_PER_BANK;
  localparam int PROD_W  = COEFF_W + IN_W;
  localparam int SUM_W   = ACC_W + 2;
  localparam logic [3:0] LP_WORDS = 4'(TAPS_PER_BANK);
  localparam logic signed [SUM_W-1:0] LP_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] LP_MIN = SUM_W'(-(2 ** (OUT_W - 1)));

  logic [COEFF_W-1:0]        r_mem  [NUM_BANK][TAPS_PER_BANK];
  logic signed [IN_W-1:0]    r_tap  [NUM_TAP];
  logic signed [COEFF_W-1:0] r_rd   [NUM_BANK];
  logic signed [IN_W-1:0]    r_tsel [NUM_BANK];
  logic signed [PROD_W-1:0]  r_prod [NUM_BANK];
  logic signed [ACC_W-1:0]   r_acc  [NUM_BANK];
  logic                      r_add_d;

  logic [1:0]              w_bank;
  logic [3:0]              w_word;
  logic                    w_word_ok;
  logic                    w_wr;
  logic                    w_rd;
  logic [5:0]              w_tap_idx;
  logic signed [SUM_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_sat;

  assign w_bank    = iAddrRam[5:4];
  assign w_word    = iAddrRam[3:0];
  assign w_word_ok = (w_word < LP_WORDS);
  // Load mode gates the direction: writes only in load mode, reads only outside it.
  assign w_wr      = iCoeffUpdateFlag & ~iCsnRam & ~iWrnRam & w_word_ok;
  assign w_rd      = ~iCoeffUpdateFlag & ~iCsnRam & iWrnRam;
  assign w_tap_idx = 6'(w_bank) * 6'(TAPS_PER_BANK) + 6'(w_word);

  // Coefficient storage is deliberately outside the reset domain.
  always_ff @(posedge iClk12M) begin
    if (w_wr) begin
      r_mem[w_bank][w_word] <= iWtDtRam;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_sum = w_sum + SUM_W'(r_acc[b]);
    end
    if (w_sum > LP_MAX) begin
      w_sat = OUT_W'(LP_MAX);
    end else if (w_sum < LP_MIN) begin
      w_sat = OUT_W'(LP_MIN);
    end else begin
      w_sat = w_sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      for (int k = 0; k < NUM_TAP; k++) begin
        r_tap[k] <= '0;
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        r_rd[b]   <= '0;
        r_tsel[b] <= '0;
        r_prod[b] <= '0;
        r_acc[b]  <= '0;
      end
      r_add_d <= 1'b0;
      oFirOut <= '0;
    end else begin
      if (iEnSample600k && !iCoeffUpdateFlag) begin
        r_tap[0] <= iFirIn;
        for (int k = 1; k < NUM_TAP; k++) begin
          r_tap[k] <= r_tap[k-1];
        end
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        // Unselected banks read zero so their products drop out of the sum.
        if (w_rd && w_word_ok && (w_bank == 2'(b))) begin
          r_rd[b]   <= r_mem[b][w_word];
          r_tsel[b] <= r_tap[w_tap_idx];
        end else begin
          r_rd[b] <= '0;
        end
        if (iEnMul) begin
          r_prod[b] <= PROD_W'(r_rd[b]) * PROD_W'(r_tsel[b]);
        end
        if (iEnAddAcc) begin
          r_acc[b] <= r_add_d ? (r_acc[b] + ACC_W'(r_prod[b])) : ACC_W'(r_prod[b]);
        end
      end
      r_add_d <= iEnAddAcc;
      // Falling edge of the accumulate window publishes the pass result.
      if (!iEnAddAcc && r_add_d) begin
        oFirOut <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_reconf_fir_filter.sv
// tb_reconf_fir_filter
// Randomized and directed stimulus for reconf_fir_filter, checked against
// a behavioural model: a coefficient table, a tap array and a pass result
// computed as a plain sum of coefficient * tap over the addresses read.
module tb_reconf_fir_filter;

  logic        iClk12M = 1'b0;
  logic        iRsn = 1'b0;
  logic        iEnSample600k = 1'b0;
  logic        iCoeffUpdateFlag = 1'b0;
  logic        iCsnRam = 1'b1;
  logic        iWrnRam = 1'b1;
  logic        iEnMul = 1'b0;
  logic        iEnAddAcc = 1'b0;
  logic [5:0]  iAddrRam = '0;
  logic [15:0] iWtDtRam = '0;
  logic [2:0]  iFirIn = '0;
  logic [15:0] oFirOut;

  reconf_fir_filter dut (
    .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample600k(iEnSample600k),
    .iCoeffUpdateFlag(iCoeffUpdateFlag), .iCsnRam(iCsnRam), .iWrnRam(iWrnRam),
    .iEnMul(iEnMul), .iEnAddAcc(iEnAddAcc), .iAddrRam(iAddrRam),
    .iWtDtRam(iWtDtRam), .iFirIn(iFirIn), .oFirOut(oFirOut)
  );

  always #5 iClk12M = ~iClk12M;

  int n_chk = 0;
  int n_fail = 0;
  int m_coef [4][10];
  int m_tap [40];
  logic [5:0] p_addr [10];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  task automatic idle();
    iEnSample600k = 1'b0;
    iCoeffUpdateFlag = 1'b0;
    iCsnRam = 1'b1;
    iWrnRam = 1'b1;
    iEnMul = 1'b0;
    iEnAddAcc = 1'b0;
    iAddrRam = '0;
  endtask

  task automatic wr(input int b, input int a, input logic [15:0] d, input bit upd);
    logic [5:0] adr;
    adr = {2'(b), 4'(a)};
    iCoeffUpdateFlag = upd;
    iCsnRam = 1'b0;
    iWrnRam = 1'b0;
    iAddrRam = adr;
    iWtDtRam = d;
    tick();
    idle();
    if (upd && a < 10) m_coef[b][a] = int'($signed(d));
  endtask

  task automatic strobe(input logic [2:0] x, input bit upd);
    iFirIn = x;
    iCoeffUpdateFlag = upd;
    iEnSample600k = 1'b1;
    tick();
    idle();
    if (!upd) begin
      for (int k = 39; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = int'($signed(x));
    end
  endtask

  function automatic logic [15:0] model_pass(input bit upd);
    int s;
    int b;
    int a;
    s = 0;
    if (!upd) begin
      for (int k = 0; k < 10; k++) begin
        b = int'(p_addr[k][5:4]);
        a = int'(p_addr[k][3:0]);
        if (a < 10) s += m_coef[b][a] * m_tap[10*b + a];
      end
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic run_pass(input bit upd, input string tag);
    logic [15:0] e;
    e = model_pass(upd);
    for (int k = 0; k <= 13; k++) begin
      iCoeffUpdateFlag = upd;
      iCsnRam = (k <= 9) ? 1'b0 : 1'b1;
      iWrnRam = 1'b1;
      iAddrRam = (k <= 9) ? p_addr[k] : 6'd0;
      iEnMul = (k >= 1 && k <= 11);
      iEnAddAcc = (k >= 2 && k <= 12);
      tick();
    end
    idle();
    chk(tag, oFirOut, e);
  endtask

  task automatic bank_addr(input int b);
    for (int k = 0; k < 10; k++) p_addr[k] = {2'(b), 4'(k)};
  endtask

  task automatic clear_model_taps();
    for (int k = 0; k < 40; k++) m_tap[k] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model_taps();
    idle();
    tick();
    // Load coefficients first: the reset that follows must not clear them.
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 10; a++)
        wr(b, a, 16'(((10 + b) << 8) + a), 1'b1);
    iRsn = 1'b1;
    tick();
    iRsn = 1'b0;
    clear_model_taps();
    chk("reset_out", oFirOut, 16'h0000);
    bank_addr(0);
    run_pass(1'b0, "reset_zero_pass");

    wr(1, 3, 16'hFFFF, 1'b0);
    wr(2, 12, 16'h1234, 1'b1);

    strobe(3'b001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      bank_addr(i / 10);
      run_pass(1'b0, $sformatf("impulse_%0d", i));
      bank_addr((i / 10 + 1) % 4);
      run_pass(1'b0, $sformatf("other_bank_%0d", i));
      if (i == 5) begin
        strobe(3'b001, 1'b1);
        bank_addr(0);
        run_pass(1'b0, "frozen_line");
      end
      strobe(3'b000, 1'b0);
    end

    strobe(3'b010, 1'b0);
    bank_addr(0);
    run_pass(1'b1, "read_in_load_mode");

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 10; a++)
        wr(b, a, 16'h7FFF, 1'b1);
    for (int k = 0; k < 40; k++) strobe(3'b011, 1'b0);
    for (int b = 0; b < 4; b++) begin
      bank_addr(b);
      run_pass(1'b0, $sformatf("sat_pos_b%0d", b));
    end
    for (int k = 0; k < 40; k++) strobe(3'b100, 1'b0);
    for (int b = 0; b < 4; b++) begin
      bank_addr(b);
      run_pass(1'b0, $sformatf("sat_neg_b%0d", b));
    end

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 10; a++)
        wr(b, a, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 3; w++)
        wr($urandom_range(0, 3), $urandom_range(0, 11), 16'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 3) != 0));
      for (int s = 0; s < int'($urandom_range(0, 5)); s++)
        strobe(3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0));
      for (int k = 0; k < 10; k++)
        p_addr[k] = {2'($urandom_range(0, 3)), 4'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9))};
      run_pass(1'b0, $sformatf("random_%0d", it));
    end

    // Reset in the middle of a pass aborts it and clears the delay line.
    for (int k = 0; k < 40; k++) strobe(3'b011, 1'b0);
    bank_addr(2);
    for (int k = 0; k <= 6; k++) begin
      iCsnRam = 1'b0;
      iWrnRam = 1'b1;
      iAddrRam = p_addr[k];
      iEnMul = (k >= 1);
      iEnAddAcc = (k >= 2);
      iRsn = (k == 6);
      tick();
    end
    iRsn = 1'b0;
    idle();
    clear_model_taps();
    tick();
    tick();
    chk("reset_mid_pass_out", oFirOut, 16'h0000);
    run_pass(1'b0, "after_reset_pass");
    strobe(3'b001, 1'b0);
    bank_addr(0);
    run_pass(1'b0, "ram_kept_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
